regfile_mp: RTL and testbench

- Parametrised register file, successor to the fixed 64x32 register block in the datapath.
- Generic width and depth; two synchronous read ports and one write port.
- Write-first bypass: a same-cycle write to the register being read is returned on the read port.
- Optional hardwired zero register, plus a hardware clear sequencer that zeroes every entry after reset and flags busy until done.

---
 rtl/regfile_mp.sv | 146 ++++++++++++++
 tb/tb_regfile_mp.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Parametrised 2-read/1-write register file with write-first bypass,
// optional hardwired zero entry and a post-reset clear sequencer.

module regfile_mp_rdport #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 6,
  parameter int ZERO_REG = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] data
);
  logic [DATA_W-1:0] data_q, data_d;

  // Zero entry beats bypass, bypass beats stored data.
  always_comb begin
    data_d = data_q;
    if (rd_en) begin
      if (ZERO_REG != 0 && addr == '0)
        data_d = '0;
      else if (wr_en && wr_addr == addr)
        data_d = wr_data;
      else
        data_d = mem_data;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) data_q <= '0;
    else          data_q <= data_d;
  end

  assign data = data_q;
endmodule

module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 6,
  parameter int ZERO_REG = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  input  logic [ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0] datain,
  output logic [DATA_W-1:0] rs_out,
  output logic [DATA_W-1:0] rt_out,
  output logic              busy
);
  localparam int DEPTH    = 1 << ADDR_W;
  localparam int NUM_PORT = 2;

  typedef enum logic {CLEAR, READY} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              ready;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [DATA_W-1:0] mem_wd;

  logic [NUM_PORT-1:0][ADDR_W-1:0] port_addr;
  logic [NUM_PORT-1:0][DATA_W-1:0] port_data;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      CLEAR: begin
        ptr_d = ptr_q + ADDR_W'(1);
        if (ptr_q == '1) state_d = READY;
      end
      READY:   state_d = READY;
      default: state_d = CLEAR;
    endcase
  end

  always_comb begin
    busy  = (state_q == CLEAR);
    ready = (state_q == READY);
  end

  // Single array write port shared by the clear sequencer and the user write;
  // nothing reaches the array on a reset edge.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = rd;
    mem_wd = datain;
    if (busy) begin
      mem_we = reset_n;
      mem_wa = ptr_q;
      mem_wd = '0;
    end else if (write && !(ZERO_REG != 0 && rd == '0)) begin
      mem_we = reset_n;
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) mem_q[mem_wa] <= mem_wd;
  end

  assign port_addr[0] = rs;
  assign port_addr[1] = rt;

  for (genvar g = 0; g < NUM_PORT; g++) begin : g_port
    regfile_mp_rdport #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .ZERO_REG(ZERO_REG)
    ) u_port (
      .clock   (clock),
      .reset_n (reset_n),
      .rd_en   (read && ready),
      .addr    (port_addr[g]),
      .wr_en   (write && ready),
      .wr_addr (rd),
      .wr_data (datain),
      .mem_data(mem_q[port_addr[g]]),
      .data    (port_data[g])
    );
  end

  assign rs_out = port_data[0];
  assign rt_out = port_data[1];
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: default 64x32 zero-reg instance plus a
// 16x16 instance without zero register.

module tb_regfile_mp;
  logic clock = 1'b0;
  always #5 clock = ~clock;

  // instance A: defaults
  logic        reset_n = 1'b0, read = 1'b0, write = 1'b0;
  logic [5:0]  rs = '0, rt = '0, rd = '0;
  logic [31:0] datain = '0;
  logic [31:0] rs_out, rt_out;
  logic        busy;

  // instance B: DATA_W=16, ADDR_W=4, ZERO_REG=0
  logic        b_reset_n = 1'b0, b_read = 1'b0, b_write = 1'b0;
  logic [3:0]  b_rs = '0, b_rt = '0, b_rd = '0;
  logic [15:0] b_datain = '0;
  logic [15:0] b_rs_out, b_rt_out;
  logic        b_busy;

  int nvec = 0;
  int nerr = 0;

  regfile_mp u_dut (
    .clock(clock), .reset_n(reset_n), .read(read), .write(write),
    .rs(rs), .rt(rt), .rd(rd), .datain(datain),
    .rs_out(rs_out), .rt_out(rt_out), .busy(busy)
  );

  regfile_mp #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(0)) u_dut_b (
    .clock(clock), .reset_n(b_reset_n), .read(b_read), .write(b_write),
    .rs(b_rs), .rt(b_rt), .rd(b_rd), .datain(b_datain),
    .rs_out(b_rs_out), .rt_out(b_rt_out), .busy(b_busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_a();
    read = 1'b0; write = 1'b0;
  endtask

  // Count edges while busy is high; gives up after 200 edges.
  task automatic count_clear_a(output int n);
    n = 0;
    while (busy && n < 200) begin
      if (n == 20) begin
        write = 1'b1; rd = 6'd9; datain = 32'h11;
        read = 1'b1; rs = 6'd9; rt = 6'd9;
      end else begin
        idle_a();
      end
      step();
      n++;
      if (n == 21) begin
        chk("clr_gate_rs", rs_out, 32'h0);
        chk("clr_gate_rt", rt_out, 32'h0);
      end
    end
    idle_a();
  endtask

  initial begin
    int n;

    // ---- reset and clear ----
    step();
    chk("rst_rs", rs_out, 32'h0);
    chk("rst_rt", rt_out, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h1);
    step();
    reset_n = 1'b1;
    count_clear_a(n);
    chk("clear_len", n, 32'd64);

    read = 1'b1; rs = 6'd9; rt = 6'd63;
    step();
    chk("busy_wr_dropped", rs_out, 32'h0);
    chk("clr_63", rt_out, 32'h0);
    rs = 6'd5;
    step();
    chk("clr_5", rs_out, 32'h0);

    // ---- write then read ----
    idle_a(); write = 1'b1; rd = 6'd7; datain = 32'hDEADBEEF;
    step();
    write = 1'b0; read = 1'b1; rs = 6'd7; rt = 6'd7;
    step();
    chk("wr_rd_rs", rs_out, 32'hDEADBEEF);
    chk("wr_rd_rt", rt_out, 32'hDEADBEEF);

    // ---- bypass ----
    idle_a(); write = 1'b1; rd = 6'd3; datain = 32'h34;
    step();
    write = 1'b1; rd = 6'd12; datain = 32'h400; read = 1'b1; rs = 6'd12; rt = 6'd3;
    step();
    chk("byp_rs", rs_out, 32'h400);
    chk("byp_rt", rt_out, 32'h34);
    write = 1'b0; rs = 6'd12;
    step();
    chk("byp_stored", rs_out, 32'h400);
    write = 1'b1; rd = 6'd20; datain = 32'h55AA; rs = 6'd20; rt = 6'd20;
    step();
    chk("byp_both_rs", rs_out, 32'h55AA);
    chk("byp_both_rt", rt_out, 32'h55AA);

    // ---- zero register ----
    write = 1'b1; rd = 6'd0; datain = 32'hFFFFFFFF; read = 1'b1; rs = 6'd0; rt = 6'd7;
    step();
    chk("zero_byp", rs_out, 32'h0);
    chk("zero_other", rt_out, 32'hDEADBEEF);
    write = 1'b0; rs = 6'd0; rt = 6'd0;
    step();
    chk("zero_later", rs_out, 32'h0);

    // ---- hold with read=0 ----
    idle_a(); write = 1'b1; rd = 6'd30; datain = 32'hA5A5A5A5;
    step();
    write = 1'b0; read = 1'b1; rs = 6'd30;
    step();
    chk("hold_pre", rs_out, 32'hA5A5A5A5);
    read = 1'b0; write = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rd = 6'(29 + i); datain = 32'h1000 + 32'(i);
      step();
      chk($sformatf("hold_%0d", i), rs_out, 32'hA5A5A5A5);
    end
    write = 1'b0; read = 1'b1; rs = 6'd30;
    step();
    chk("hold_after", rs_out, 32'h1001);

    // ---- mid-clear reset ----
    idle_a(); reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 30; i++) step();
    chk("mid_busy", {31'h0, busy}, 32'h1);
    chk("mid_rs", rs_out, 32'h0);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    n = 0;
    while (busy && n < 200) begin
      step();
      n++;
    end
    chk("mid_clear_len", n, 32'd64);
    read = 1'b1; rs = 6'd7; rt = 6'd30;
    step();
    chk("reclr_7", rs_out, 32'h0);
    chk("reclr_30", rt_out, 32'h0);
    idle_a();

    // ---- instance B: 16x16, no zero register ----
    b_reset_n = 1'b0;
    step();
    step();
    b_reset_n = 1'b1;
    n = 0;
    while (b_busy && n < 100) begin
      step();
      n++;
    end
    chk("b_clear_len", n, 32'd16);
    b_write = 1'b1; b_rd = 4'd15; b_datain = 16'hBEEF;
    step();
    b_write = 1'b0; b_read = 1'b1; b_rs = 4'd15; b_rt = 4'd14;
    step();
    chk("b_wr_rd", {16'h0, b_rs_out}, 32'hBEEF);
    chk("b_clr_14", {16'h0, b_rt_out}, 32'h0);
    b_write = 1'b1; b_rd = 4'd0; b_datain = 16'hFFFF; b_rs = 4'd0; b_rt = 4'd15;
    step();
    chk("b_r0_byp", {16'h0, b_rs_out}, 32'hFFFF);
    b_write = 1'b0;
    step();
    chk("b_r0_later", {16'h0, b_rs_out}, 32'hFFFF);
    chk("b_r15", {16'h0, b_rt_out}, 32'hBEEF);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
